// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, byte index type and buffer state encoding for the AES output stage
package aes_pkg;
  localparam int BYTES_PER_BLOCK = 16;
  typedef logic [3:0] byte_idx_t;
  typedef enum logic [1:0] {EMPTY, STREAM, FULL} ser_state_t;
  localparam byte_idx_t LAST_BYTE = byte_idx_t'(BYTES_PER_BLOCK - 1);
endpackage

// File: rtl/aes_blk_fifo.sv
// aes_blk_fifo: DEPTH x DATA_LEN circular block buffer with pointers, occupancy and registered state
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DATA_LEN = 128,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [DATA_LEN-1:0] i_data,
  output logic [DATA_LEN-1:0] o_head,
  output ser_state_t          o_state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  logic [DATA_LEN-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count, w_count_nxt;
  ser_state_t r_state;
  logic w_wr;
  // a final-byte pop frees the head slot in time for a push into a full buffer
  assign w_wr = i_push && (r_state != FULL || i_pop);
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, i_pop};
  assign o_head = r_mem[r_rd_ptr];
  assign o_state = r_state;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= EMPTY;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_wr);
      r_rd_ptr <= r_rd_ptr + AW'(i_pop);
      r_count  <= w_count_nxt;
      r_state  <= w_count_nxt == '0 ? EMPTY : w_count_nxt == CNT_FULL ? FULL : STREAM;
    end
endmodule

// File: rtl/aes_ct_serializer.sv
// aes_ct_serializer: buffers AES cipher blocks and streams them MSB byte first; AES_SER_LAST_EN adds byte_last
module aes_ct_serializer
  import aes_pkg::*;
#(
  parameter int DATA_LEN = 128,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ct_valid_in,
  input  logic [DATA_LEN-1:0] ct_in,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  input  logic                byte_ready,
`ifdef AES_SER_LAST_EN
  output logic                byte_last,
`endif
  output logic                buf_full,
  output logic                overflow,
  input  logic                ovf_clr
);
  byte_idx_t r_byte_idx;
  logic [DATA_LEN-1:0] w_head, w_sh;
  ser_state_t w_state;
  logic w_hs, w_pop, w_drop, r_ovf;
  aes_blk_fifo #(.DATA_LEN(DATA_LEN), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (ct_valid_in),
    .i_pop  (w_pop),
    .i_data (ct_in),
    .o_head (w_head),
    .o_state(w_state)
  );
  assign byte_valid = w_state != EMPTY;
  assign w_hs = byte_valid && byte_ready;
  assign w_pop = w_hs && r_byte_idx == LAST_BYTE;
  assign w_drop = ct_valid_in && w_state == FULL && !w_pop;
  // output is gated so stale buffer contents never show while idle
  assign w_sh = w_head << {r_byte_idx, 3'b000};
  assign byte_data = byte_valid ? w_sh[DATA_LEN-1 -: 8] : 8'h00;
  assign buf_full = w_state == FULL;
  assign overflow = r_ovf;
`ifdef AES_SER_LAST_EN
  assign byte_last = byte_valid && r_byte_idx == LAST_BYTE;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_byte_idx <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_byte_idx <= w_hs ? (w_pop ? '0 : r_byte_idx + 1'b1) : r_byte_idx;
      r_ovf      <= w_drop || (r_ovf && !ovf_clr);
    end
endmodule

// File: tb/tb_aes_ct_serializer.sv
// tb_aes_ct_serializer: randomized + directed scoreboard bench for aes_ct_serializer
module tb_aes_ct_serializer;
  localparam int DEPTH = 2;
  logic clk = 0, reset = 0, ct_valid_in = 0, byte_ready = 0, ovf_clr = 0;
  logic [127:0] ct_in = '0;
  logic byte_valid, buf_full, overflow;
  logic [7:0] byte_data;
`ifdef AES_SER_LAST_EN
  logic byte_last;
`endif
  int checks = 0, errors = 0;
  logic [127:0] mq[$];
  logic [8:0] sb[$];
  int midx = 0;
  logic movf = 0;

  aes_ct_serializer #(.DATA_LEN(128), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ct_valid_in(ct_valid_in), .ct_in(ct_in),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
`ifdef AES_SER_LAST_EN
    .byte_last(byte_last),
`endif
    .buf_full(buf_full), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // reference model: bounded queue of whole blocks plus a byte counter into the head block
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mq.delete();
      sb.delete();
      midx = 0;
      movf = 0;
    end else begin
      logic drop;
      drop = 0;
      if (mq.size() != 0 && byte_ready) begin
        midx++;
        if (midx == 16) begin
          midx = 0;
          void'(mq.pop_front());
        end
      end
      if (ct_valid_in) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(ct_in);
          for (int i = 0; i < 16; i++) sb.push_back({i == 15, 8'(ct_in >> (8 * (15 - i)))});
        end else drop = 1;
      end
      movf = drop ? 1'b1 : (ovf_clr ? 1'b0 : movf);
    end
  end

  // monitor: status against the model, transferred bytes against the scoreboard
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("byte_valid", 32'(byte_valid), 32'(mq.size() != 0));
      chk("buf_full", 32'(buf_full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(movf));
      if (byte_valid && byte_ready) begin
        if (sb.size() == 0) chk("extra_byte", 32'(byte_data), 32'hffff_ffff);
        else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("byte_data", 32'(byte_data), 32'(e[7:0]));
`ifdef AES_SER_LAST_EN
          chk("byte_last", 32'(byte_last), 32'(e[8]));
`endif
        end
      end
    end
  end

  task automatic step(input logic v, input logic [127:0] d, input logic rdy, input logic clr);
    ct_valid_in = v;
    ct_in = d;
    byte_ready = rdy;
    ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, '0, rdy, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [127:0] k, a, b, c;
    k = 128'h0336763e966d92595a567cc9ce537f5e;
    a = rnd128(); b = rnd128(); c = rnd128();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(byte_valid), 0);
    chk("rst_data", 32'(byte_data), 0);
    chk("rst_full", 32'(buf_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1;
    step(1, k, 1, 0);
    chk("first_byte", 32'(byte_data), 32'h03);
    idle(20, 1);
    step(1, k, 1, 0);
    for (int i = 0; i < 40; i++) step(0, '0, 1'(i % 2), 0);
    step(1, a, 0, 0);
    step(1, b, 0, 0);
    chk("full_after_b", 32'(buf_full), 1);
    step(1, c, 0, 0);
    chk("ovf_after_c", 32'(overflow), 1);
    idle(3, 0);
    step(1, c, 0, 1);
    chk("ovf_set_wins", 32'(overflow), 1);
    step(0, '0, 0, 1);
    chk("ovf_cleared", 32'(overflow), 0);
    idle(40, 1);
    step(1, a, 0, 0);
    step(1, b, 0, 0);
    idle(15, 1);
    step(1, c, 1, 0);
    chk("pop_push_full_ovf", 32'(overflow), 0);
    chk("pop_push_full", 32'(buf_full), 1);
    idle(60, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) == 0, rnd128(), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 15) == 0);
    idle(60, 1);
    step(1, a, 1, 0);
    idle(5, 1);
    reset = 0;
    #1;
    chk("midrst_valid", 32'(byte_valid), 0);
    chk("midrst_data", 32'(byte_data), 0);
    chk("midrst_full", 32'(buf_full), 0);
    chk("midrst_ovf", 32'(overflow), 0);
    @(posedge clk);
    #1;
    reset = 1;
    step(1, b, 1, 0);
    chk("restart_byte0", 32'(byte_data), 32'(b[127:120]));
    idle(20, 1);
    chk("leftover", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
